// File: rtl/seq_gen_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// seq_gen_arbiter_pkg
// Shared types and constants for the sequence_gen front-end arbiter.
//   ulogicN       : plain logic vector typedefs reused across the slice
//   arb_state_t   : arbiter FSM states
//   arb_status_t  : status code returned with every result
//   LOAD_CYCLES   : length of the engine load handshake
//   wrap_inc()    : modulo increment used for the round-robin pointer
// -----------------------------------------------------------------------------
package seq_gen_arbiter_pkg;

  typedef logic [15:0] ulogic16;
  typedef logic [16:0] ulogic17;
  typedef logic [63:0] ulogic64;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT,
    RESP,
    CLEAR
  } arb_state_t;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_OVF     = 2'd1,
    ST_ERR     = 2'd2,
    ST_TIMEOUT = 2'd3
  } arb_status_t;

  // The engine expects load held high for this many cycles.
  localparam int LOAD_CYCLES = 2;

  // Increment idx, wrapping to 0 once it reaches n.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/seq_gen_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin picker: selects the first asserted request
// at or after ptr, wrapping modulo NUM_REQ.
// Ports:
//   req   in  NUM_REQ  request vector
//   ptr   in  ID_W     highest-priority index for this decision
//   grant out NUM_REQ  one-hot grant (all zero when no request)
//   index out ID_W     encoded index of the granted requester
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    index
);

  always_comb begin
    int cand;
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment; a path that leaves one unassigned infers a latch.
    grant = '0;
    index = '0;
    cand  = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(ptr) + k) % NUM_REQ;
      // Only the first hit in rotated order wins.
      if (grant == '0 && req[ID_W'(cand)]) begin
        grant[ID_W'(cand)] = 1'b1;
        index              = ID_W'(cand);
      end
    end
  end

endmodule

// File: rtl/seq_gen_arbiter.sv
// -----------------------------------------------------------------------------
// seq_gen_arbiter
// Shares one sequence_gen engine between NUM_REQ clients. A round-robin pick
// latches the winner's mode/order/data, drives the 2-cycle load handshake,
// waits for error/overflow/done, returns a tagged result, then pulses clear.
//
// Optional feature: define SEQ_GEN_ARB_WATCHDOG_EN to abort a job whose WAIT
// phase lasts order+2+WD_SLACK cycles (status TIMEOUT, rsp_data 0).
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   req/req_mode/req_order/req_data  per-client request and job fields
//   gnt                          one-hot 1-cycle accept pulse
//   rsp_valid/rsp_id/rsp_data/rsp_status  tagged result, 1-cycle pulse
//   busy                         high from grant through CLEAR
//   load/clear/fibonacci/triangle/order/data_in  engine controls
//   done/overflow/error/data_out engine completion and result
// -----------------------------------------------------------------------------
module seq_gen_arbiter
  import seq_gen_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int ID_W     = $clog2(NUM_REQ)
`ifdef SEQ_GEN_ARB_WATCHDOG_EN
  ,
  parameter int WD_SLACK = 8
`endif
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   req_mode,
  input  logic [NUM_REQ*16-1:0] req_order,
  input  logic [NUM_REQ*64-1:0] req_data,
  output logic [NUM_REQ-1:0]   gnt,
  output logic                 rsp_valid,
  output logic [ID_W-1:0]      rsp_id,
  output logic [63:0]          rsp_data,
  output logic [1:0]           rsp_status,
  output logic                 busy,
  output logic                 load,
  output logic                 clear,
  output logic                 fibonacci,
  output logic                 triangle,
  output logic [15:0]          order,
  output logic [63:0]          data_in,
  input  logic                 done,
  input  logic                 overflow,
  input  logic                 error,
  input  logic [63:0]          data_out
);

  localparam int LOAD_CNT_W = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;

  arb_state_t             state;
  arb_state_t             state_d;
  logic [ID_W-1:0]        ptr;
  logic [NUM_REQ-1:0]     arb_grant;
  logic [ID_W-1:0]        arb_index;
  logic                   armed;
  logic                   accept;
  logic                   finish;
  arb_status_t            status_d;
  ulogic64                result_d;
  logic                   drive_job;
  logic                   last_load;
  logic [LOAD_CNT_W-1:0]  load_cnt;

  // Job latched at grant; drives the engine until CLEAR.
  logic [ID_W-1:0]        job_id;
  logic                   job_mode;
  ulogic16                job_order;
  ulogic64                job_data;

  ulogic64                rsp_data_q;
  arb_status_t            rsp_status_q;

  // Per-client views of the flattened order/data buses.
  ulogic16 order_arr [NUM_REQ];
  ulogic64 data_arr  [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign order_arr[g] = req_order[g*16 +: 16];
    assign data_arr[g]  = req_data[g*64 +: 64];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .req   (req),
    .ptr   (ptr),
    .grant (arb_grant),
    .index (arb_index)
  );

  assign last_load = (load_cnt == LOAD_CNT_W'(LOAD_CYCLES - 1));

`ifdef SEQ_GEN_ARB_WATCHDOG_EN
  ulogic17 wd_cnt;
  logic    wd_expired;

  // wd_cnt is 0 in the first WAIT cycle, so the limit is one less than the
  // WAIT length; 17 bits keep order+WD_SLACK+1 from wrapping at order=FFFF.
  assign wd_expired = (wd_cnt == ({1'b0, job_order} + 17'(WD_SLACK + 1)));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt <= '0;
    end else if (state == WAIT) begin
      wd_cnt <= wd_cnt + 17'd1;
    end else begin
      wd_cnt <= '0;
    end
  end
`endif

  // Next-state and output decode.
  always_comb begin
    state_d  = state;
    accept   = 1'b0;
    finish   = 1'b0;
    status_d = ST_OK;
    result_d = data_out;

    case (state)
      IDLE: begin
        // armed keeps gnt low until the first clock after reset release.
        if (armed && (|req)) begin
          accept  = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (last_load) state_d = WAIT;
      end
      WAIT: begin
        if (error) begin
          finish   = 1'b1;
          status_d = ST_ERR;
        end else if (overflow) begin
          finish   = 1'b1;
          status_d = ST_OVF;
        end else if (done) begin
          finish   = 1'b1;
          status_d = ST_OK;
        end
`ifdef SEQ_GEN_ARB_WATCHDOG_EN
        else if (wd_expired) begin
          finish   = 1'b1;
          status_d = ST_TIMEOUT;
          result_d = '0;
        end
`endif
        if (finish) state_d = RESP;
      end
      RESP:    state_d = CLEAR;
      CLEAR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Engine inputs follow the latched job from LOAD until CLEAR.
    drive_job  = (state == LOAD) || (state == WAIT) || (state == RESP);
    gnt        = accept ? arb_grant : '0;
    load       = (state == LOAD);
    clear      = (state == CLEAR);
    fibonacci  = drive_job && !job_mode;
    triangle   = drive_job && job_mode;
    order      = drive_job ? job_order : '0;
    data_in    = drive_job ? job_data : '0;
    rsp_valid  = (state == RESP);
    rsp_id     = job_id;
    rsp_data   = rsp_data_q;
    rsp_status = rsp_status_q;
    busy       = (state != IDLE) || accept;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      armed        <= 1'b0;
      ptr          <= '0;
      job_id       <= '0;
      job_mode     <= 1'b0;
      job_order    <= '0;
      job_data     <= '0;
      load_cnt     <= '0;
      rsp_data_q   <= '0;
      rsp_status_q <= ST_OK;
    end else begin
      armed <= 1'b1;

      if (accept) begin
        job_id    <= arb_index;
        job_mode  <= req_mode[arb_index];
        job_order <= order_arr[arb_index];
        job_data  <= data_arr[arb_index];
        ptr       <= ID_W'(wrap_inc(int'(arb_index), NUM_REQ));
      end

      load_cnt <= (state == LOAD) ? load_cnt + LOAD_CNT_W'(1) : '0;

      if (finish) begin
        rsp_data_q   <= result_d;
        rsp_status_q <= status_d;
      end
    end
  end

endmodule

// File: tb/tb_seq_gen_arbiter.sv
// -----------------------------------------------------------------------------
// tb_seq_gen_arbiter
// Self-checking bench for seq_gen_arbiter. Expected responses are queued when
// a job is started and popped when rsp_valid appears. Inputs change 1 time
// unit after a rising edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_seq_gen_arbiter;

  localparam int NUM_REQ  = 4;
  localparam int ID_W     = 2;
  localparam int WD_SLACK = 8;
  localparam int TMO      = 200;

  typedef struct {
    logic [ID_W-1:0] id;
    logic [63:0]     data;
    logic [1:0]      status;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  logic                  clk = 1'b0;
  logic                  reset_n = 1'b0;
  logic [NUM_REQ-1:0]    req = '0;
  logic [NUM_REQ-1:0]    req_mode = '0;
  logic [NUM_REQ*16-1:0] req_order = '0;
  logic [NUM_REQ*64-1:0] req_data = '0;
  logic [NUM_REQ-1:0]    gnt;
  logic                  rsp_valid;
  logic [ID_W-1:0]       rsp_id;
  logic [63:0]           rsp_data;
  logic [1:0]            rsp_status;
  logic                  busy, load, clear, fibonacci, triangle;
  logic [15:0]           order;
  logic [63:0]           data_in;
  logic                  done = 1'b0, overflow = 1'b0, error = 1'b0;
  logic [63:0]           data_out = '0;

  always #5 clk = ~clk;

  seq_gen_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .clk(clk), .reset_n(reset_n),
    .req(req), .req_mode(req_mode), .req_order(req_order), .req_data(req_data),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_status(rsp_status), .busy(busy), .load(load), .clear(clear),
    .fibonacci(fibonacci), .triangle(triangle), .order(order), .data_in(data_in),
    .done(done), .overflow(overflow), .error(error), .data_out(data_out)
  );

  // ---------------- stimulus / observation helpers (no checking) -----------
  function automatic logic [1:0] model_status(input logic e, input logic o);
    return e ? 2'd2 : (o ? 2'd1 : 2'd0);
  endfunction

  function automatic bit all_zero();
    return gnt == '0 && !rsp_valid && rsp_id == '0 && rsp_data == '0 &&
           rsp_status == '0 && !busy && !load && !clear && !fibonacci &&
           !triangle && order == '0 && data_in == '0;
  endfunction

  function automatic bit pop_exp(output exp_t e);
    e = '{default: '0};
    if (exp_q.size() == 0) return 1'b0;
    e = exp_q.pop_front();
    return 1'b1;
  endfunction

  task automatic set_client(input int c, input logic m, input logic [15:0] o,
                            input logic [63:0] d);
    req_mode[c]          = m;
    req_order[c*16 +: 16] = o;
    req_data[c*64 +: 64]  = d;
  endtask

  task automatic push_exp(input int c, input logic [63:0] d, input logic [1:0] s);
    exp_t e;
    e.id = ID_W'(c); e.data = d; e.status = s;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; req = '0; done = 1'b0; overflow = 1'b0; error = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic wait_gnt(output logic [NUM_REQ-1:0] g, output int waited,
                          output bit ok);
    g = '0; ok = 1'b0; waited = 0;
    for (int i = 0; i < TMO; i++) begin
      @(negedge clk);
      waited++;
      if (gnt !== '0) begin g = gnt; ok = 1'b1; return; end
    end
  endtask

  // Called at the grant sample point; returns at the first WAIT cycle.
  task automatic watch_load(output int n_load, output int n_fib, output int n_tri,
                            output logic [15:0] ord_ld, output logic [63:0] din_ld,
                            output logic [15:0] ord_wait);
    n_load = 0; n_fib = 0; n_tri = 0; ord_ld = '0; din_ld = '0; ord_wait = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (!load) begin ord_wait = order; return; end
      n_load++;
      if (fibonacci) n_fib++;
      if (triangle) n_tri++;
      ord_ld = order; din_ld = data_in;
    end
  endtask

  task automatic pulse_completion(input logic e, input logic o, input logic d,
                                  input logic [63:0] v, input int delay);
    repeat (delay) @(negedge clk);
    @(posedge clk); #1;
    error = e; overflow = o; done = d; data_out = v;
    @(posedge clk); #1;
    error = 1'b0; overflow = 1'b0; done = 1'b0; data_out = '0;
  endtask

  task automatic wait_rsp(output logic [ID_W-1:0] id, output logic [63:0] d,
                          output logic [1:0] st, output int waited, output bit ok);
    id = '0; d = '0; st = '0; waited = 0; ok = 1'b0;
    for (int i = 0; i < TMO; i++) begin
      @(negedge clk);
      waited++;
      if (rsp_valid) begin id = rsp_id; d = rsp_data; st = rsp_status; ok = 1'b1; return; end
    end
  endtask

  // ---------------------------------- tests -----------------------------------
  task automatic test_reset();
    logic [NUM_REQ-1:0] g; int w, nl, nf, nt; bit ok; int seen;
    logic [15:0] ol, ow; logic [63:0] dl, d; logic [ID_W-1:0] id; logic [1:0] st;
    exp_t e;
    repeat (3) @(negedge clk);
    total++;
    if (!all_zero()) begin bad++; $display("FAIL reset_outputs: some output nonzero during reset, want all 0"); end
    reset_n = 1'b1;

    // Start a job for client 2 and kill it mid-WAIT.
    set_client(2, 1'b0, 16'd6, 64'd3);
    @(posedge clk); #1; req = 4'b0100;
    wait_gnt(g, w, ok);
    @(posedge clk); #1; req = '0;
    watch_load(nl, nf, nt, ol, dl, ow);
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    total++;
    if (!all_zero()) begin bad++; $display("FAIL reset_mid_wait: busy=%0b load=%0b order=%0d, want all 0", busy, load, order); end
    @(posedge clk); #1; done = 1'b1;
    @(negedge clk); reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    done = 1'b0;
    total++;
    if (seen != 0) begin bad++; $display("FAIL reset_no_rsp: rsp_valid seen %0d times, want 0", seen); end

    // Pointer must be back at 0: client 1 wins over client 3.
    set_client(1, 1'b0, 16'd5, 64'd1);
    set_client(3, 1'b1, 16'd9, 64'd2);
    push_exp(1, 64'h0BAD_F00D, 2'd0);
    @(posedge clk); #1; req = 4'b1010;
    wait_gnt(g, w, ok);
    @(posedge clk); #1; req = '0;
    total++;
    if (!ok || g !== 4'b0010) begin bad++; $display("FAIL reset_ptr_gnt: got %b want 0010", g); end
    watch_load(nl, nf, nt, ol, dl, ow);
    pulse_completion(1'b0, 1'b0, 1'b1, 64'h0BAD_F00D, 1);
    wait_rsp(id, d, st, w, ok);
    total++;
    if (!ok || !pop_exp(e) || {id, d, st} !== {e.id, e.data, e.status}) begin
      bad++; $display("FAIL reset_job_rsp: got ok=%0b id=%0d data=%h st=%0d want id=%0d data=%h st=%0d", ok, id, d, st, e.id, e.data, e.status);
    end
  endtask

  task automatic test_single_job();
    logic [NUM_REQ-1:0] g; int w, nl, nf, nt; bit ok;
    logic [15:0] ol, ow; logic [63:0] dl, d; logic [ID_W-1:0] id; logic [1:0] st;
    exp_t e;
    set_client(2, 1'b0, 16'd10, 64'd1);
    push_exp(2, 64'd55, 2'd0);
    @(posedge clk); #1; req = 4'b0100;
    wait_gnt(g, w, ok);
    @(posedge clk); #1; req = '0;
    total++;
    if (!ok || g !== 4'b0100) begin bad++; $display("FAIL single_gnt: got %b want 0100", g); end
    watch_load(nl, nf, nt, ol, dl, ow);
    total++;
    if (nl != 2 || nf != 2 || nt != 0) begin
      bad++; $display("FAIL single_load: load=%0d fib=%0d tri=%0d cycles, want 2/2/0", nl, nf, nt);
    end
    total++;
    if (ol !== 16'd10 || dl !== 64'd1 || ow !== 16'd10) begin
      bad++; $display("FAIL single_fields: order=%0d data_in=%0d wait_order=%0d, want 10/1/10", ol, dl, ow);
    end
    pulse_completion(1'b0, 1'b0, 1'b1, 64'd55, 10);
    wait_rsp(id, d, st, w, ok);
    total++;
    if (!ok || !pop_exp(e) || {id, d, st} !== {e.id, e.data, e.status}) begin
      bad++; $display("FAIL single_rsp: got ok=%0b id=%0d data=%0d st=%0d want id=%0d data=%0d st=%0d", ok, id, d, st, e.id, e.data, e.status);
    end
    @(negedge clk);
    total++;
    if (clear !== 1'b1 || busy !== 1'b1 || fibonacci || triangle || order != 0 || data_in != 0) begin
      bad++; $display("FAIL single_clear: clear=%0b busy=%0b fib=%0b order=%0d, want 1/1/0/0", clear, busy, fibonacci, order);
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || clear !== 1'b0) begin bad++; $display("FAIL single_idle: busy=%0b clear=%0b want 0/0", busy, clear); end
  endtask

  task automatic test_triangle();
    logic [NUM_REQ-1:0] g; int w, nl, nf, nt; bit ok;
    logic [15:0] ol, ow; logic [63:0] dl, d; logic [ID_W-1:0] id; logic [1:0] st;
    exp_t e;
    set_client(1, 1'b1, 16'd4, 64'd1);
    push_exp(1, 64'd10, 2'd0);
    @(posedge clk); #1; req = 4'b0010;
    wait_gnt(g, w, ok);
    @(posedge clk); #1; req = '0;
    total++;
    if (!ok || g !== 4'b0010) begin bad++; $display("FAIL tri_gnt: got %b want 0010", g); end
    watch_load(nl, nf, nt, ol, dl, ow);
    total++;
    if (nl != 2 || nt != 2 || nf != 0 || ow !== 16'd4) begin
      bad++; $display("FAIL tri_load: load=%0d tri=%0d fib=%0d wait_order=%0d, want 2/2/0/4", nl, nt, nf, ow);
    end
    pulse_completion(1'b0, 1'b0, 1'b1, 64'd10, 3);
    wait_rsp(id, d, st, w, ok);
    total++;
    if (!ok || !pop_exp(e) || {id, d, st} !== {e.id, e.data, e.status}) begin
      bad++; $display("FAIL tri_rsp: got ok=%0b id=%0d data=%0d st=%0d want id=%0d data=%0d st=%0d", ok, id, d, st, e.id, e.data, e.status);
    end
  endtask

  task automatic test_overflow_error();
    // client, order, error, overflow, done, data_out
    int          cl [3] = '{0, 3, 1};
    logic [15:0] od [3] = '{16'd0, 16'hFFFF, 16'd7};
    logic        ee [3] = '{1'b0, 1'b1, 1'b0};
    logic        oo [3] = '{1'b1, 1'b0, 1'b1};
    logic        dd [3] = '{1'b0, 1'b1, 1'b1};
    logic [63:0] vv [3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hDEAD_BEEF, 64'h1234};
    logic [NUM_REQ-1:0] g; int w, nl, nf, nt; bit ok;
    logic [15:0] ol, ow; logic [63:0] dl, d; logic [ID_W-1:0] id; logic [1:0] st;
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      set_client(cl[k], 1'b0, od[k], 64'd1);
      push_exp(cl[k], vv[k], model_status(ee[k], oo[k]));
      @(posedge clk); #1; req = NUM_REQ'(1) << cl[k];
      wait_gnt(g, w, ok);
      @(posedge clk); #1; req = '0;
      watch_load(nl, nf, nt, ol, dl, ow);
      total++;
      if (ol !== od[k]) begin bad++; $display("FAIL prio_order[%0d]: got %h want %h", k, ol, od[k]); end
      pulse_completion(ee[k], oo[k], dd[k], vv[k], 2);
      wait_rsp(id, d, st, w, ok);
      total++;
      if (!ok || !pop_exp(e) || {id, d, st} !== {e.id, e.data, e.status}) begin
        bad++; $display("FAIL prio_rsp[%0d]: got ok=%0b id=%0d data=%h st=%0d want id=%0d data=%h st=%0d", k, ok, id, d, st, e.id, e.data, e.status);
      end
    end
  endtask

  task automatic test_spurious_completion();
    logic [NUM_REQ-1:0] g; int w, seen; bit ok;
    logic [63:0] d; logic [ID_W-1:0] id; logic [1:0] st;
    exp_t e;
    repeat (2) @(negedge clk);
    @(posedge clk); #1; done = 1'b1; overflow = 1'b1; error = 1'b1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rsp_valid || busy) seen++;
    end
    done = 1'b0; overflow = 1'b0; error = 1'b0;
    total++;
    if (seen != 0) begin bad++; $display("FAIL idle_completion: rsp/busy seen %0d cycles, want 0", seen); end

    // error/overflow held through both LOAD cycles must be ignored.
    set_client(0, 1'b1, 16'd7, 64'h77);
    push_exp(0, 64'hABC, 2'd0);
    @(posedge clk); #1; req = 4'b0001;
    wait_gnt(g, w, ok);
    @(posedge clk); #1; req = '0; error = 1'b1; overflow = 1'b1;
    @(negedge clk);
    @(negedge clk);
    error = 1'b0; overflow = 1'b0;
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b0 || load !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL load_completion: rsp_valid=%0b load=%0b busy=%0b want 0/0/1", rsp_valid, load, busy);
    end
    pulse_completion(1'b0, 1'b0, 1'b1, 64'hABC, 1);
    wait_rsp(id, d, st, w, ok);
    total++;
    if (!ok || !pop_exp(e) || {id, d, st} !== {e.id, e.data, e.status}) begin
      bad++; $display("FAIL load_completion_rsp: got ok=%0b id=%0d data=%h st=%0d want id=%0d data=%h st=%0d", ok, id, d, st, e.id, e.data, e.status);
    end
  endtask

  task automatic test_fairness();
    logic [NUM_REQ-1:0] g; int w, nl, nf, nt; bit ok; int want;
    logic [15:0] ol, ow; logic [63:0] dl, d; logic [ID_W-1:0] id; logic [1:0] st;
    exp_t e;
    do_reset();
    for (int c = 0; c < NUM_REQ; c++) set_client(c, c[0], 16'(c + 1), 64'(c));
    @(posedge clk); #1; req = '1;
    for (int k = 0; k < 5; k++) begin
      want = k % NUM_REQ;
      push_exp(want, 64'(100 + k), 2'd0);
      wait_gnt(g, w, ok);
      if (k == 4) begin @(posedge clk); #1; req = '0; end
      total++;
      if (!ok || g !== (NUM_REQ'(1) << want)) begin bad++; $display("FAIL fair_gnt[%0d]: got %b want client %0d", k, g, want); end
      if (k > 0) begin
        total++;
        if (w != 1) begin bad++; $display("FAIL fair_gap[%0d]: gnt %0d cycles after clear, want 1", k, w); end
      end
      watch_load(nl, nf, nt, ol, dl, ow);
      pulse_completion(1'b0, 1'b0, 1'b1, 64'(100 + k), 2);
      wait_rsp(id, d, st, w, ok);
      total++;
      if (!ok || !pop_exp(e) || {id, d, st} !== {e.id, e.data, e.status}) begin
        bad++; $display("FAIL fair_rsp[%0d]: got ok=%0b id=%0d data=%0d st=%0d want id=%0d data=%0d", k, ok, id, d, st, e.id, e.data);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_watchdog();
    logic [NUM_REQ-1:0] g; int w, nl, nf, nt; bit ok;
    logic [15:0] ol, ow; logic [63:0] dl;
`ifdef SEQ_GEN_ARB_WATCHDOG_EN
    logic [63:0] d; logic [ID_W-1:0] id; logic [1:0] st; exp_t e;
`else
    int seen;
`endif
    set_client(2, 1'b0, 16'd3, 64'd9);
`ifdef SEQ_GEN_ARB_WATCHDOG_EN
    push_exp(2, 64'h0, 2'd3);
`endif
    @(posedge clk); #1; req = 4'b0100;
    wait_gnt(g, w, ok);
    @(posedge clk); #1; req = '0;
    watch_load(nl, nf, nt, ol, dl, ow);
`ifdef SEQ_GEN_ARB_WATCHDOG_EN
    wait_rsp(id, d, st, w, ok);
    total++;
    if (!ok || w != 3 + 2 + WD_SLACK) begin bad++; $display("FAIL wd_latency: WAIT lasted %0d cycles, want %0d", w, 3 + 2 + WD_SLACK); end
    total++;
    if (!ok || !pop_exp(e) || {id, d, st} !== {e.id, e.data, e.status}) begin
      bad++; $display("FAIL wd_rsp: got id=%0d data=%h st=%0d want id=%0d data=%h st=%0d", id, d, st, e.id, e.data, e.status);
    end
`else
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (rsp_valid || !busy) seen++;
    end
    total++;
    if (seen != 0) begin bad++; $display("FAIL wd_off_hold: %0d cycles with rsp_valid or !busy, want 0", seen); end
    do_reset();
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL wd_off_recover: busy=%0b want 0", busy); end
`endif
  endtask

  initial begin
    test_reset();
    test_single_job();
    test_triangle();
    test_overflow_error();
    test_spurious_completion();
    test_fairness();
    test_watchdog();
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_drain: %0d expected responses left, want 0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
